// File: rtl/renode_ahb_memory_subordinate.sv
// AHB-Lite subordinate backed by a word-addressed memory array.
// Every OKAY data phase gets WaitStates hready-low cycles; illegal beats get the 2-cycle ERROR.
module renode_ahb_memory_subordinate #(
   parameter int unsigned AddressWidth = 32,
   parameter int unsigned DataWidth    = 32,
   parameter int unsigned Depth        = 1024,
   parameter int unsigned BaseAddress  = 0,
   parameter int unsigned WaitStates   = 0
) (
   input  logic                     hclk,
   input  logic                     hresetn,
   input  logic                     hsel,
   input  logic [AddressWidth-1:0]  haddr,
   input  logic [1:0]               htrans,
   input  logic                     hwrite,
   input  logic [2:0]               hsize,
   input  logic [2:0]               hburst,
   input  logic [DataWidth/8-1:0]   hwstrb,
   input  logic [DataWidth-1:0]     hwdata,
   output logic                     hready,
   output logic                     hresp,
   output logic [DataWidth-1:0]     hrdata
);

   localparam int unsigned Bytes    = DataWidth / 8;
   localparam int unsigned ByteBits = $clog2(Bytes);
   localparam int unsigned IdxW     = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW     = 4;
   localparam logic [63:0] AddrLo   = 64'(BaseAddress);
   localparam logic [63:0] AddrHi   = AddrLo + 64'(Depth) * 64'(Bytes);
   localparam logic [CntW-1:0] CntLoad = CntW'((WaitStates == 0) ? 0 : WaitStates - 1);

   typedef enum logic [2:0] {
      StIdle,
      StWait,
      StData,
      StErr1,
      StErr2
   } state_e;

   state_e                  state_q, state_d;
   logic [CntW-1:0]         cnt_q, cnt_d;
   logic [AddressWidth-1:0] addr_q;
   logic                    write_q;
   logic [2:0]              size_q;
   logic                    legal_q;

   logic                    accept;
   logic                    legal;
   logic [63:0]             haddr_w;
   logic                    size_ok, align_ok, range_ok;
   logic [IdxW-1:0]         idx;
   logic                    mem_we;

   logic [DataWidth-1:0]    mem [Depth];

   assign accept  = hready & hsel & htrans[1];
   assign haddr_w = 64'(haddr);

   // Alignment and range are checked on the full 64-bit address so no parameter mix can wrap.
   assign size_ok  = (hsize <= 3'(ByteBits));
   assign align_ok = ((haddr_w & ((64'd1 << hsize) - 64'd1)) == 64'd0);
   assign range_ok = (haddr_w >= AddrLo) && (haddr_w < AddrHi);
   assign legal    = size_ok & align_ok & range_ok;

   assign idx = IdxW'((64'(addr_q) - AddrLo) >> ByteBits);

   // State register, wait counter and the address-phase fields latched on accept.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         addr_q  <= '0;
         write_q <= 1'b0;
         size_q  <= '0;
         legal_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            addr_q  <= haddr;
            write_q <= hwrite;
            size_q  <= hsize;
            legal_q <= legal;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle, StData, StErr2: begin
            if (accept) begin
               if (!legal) begin
                  state_d = StErr1;
               end else if (WaitStates == 0) begin
                  state_d = StData;
               end else begin
                  state_d = StWait;
                  cnt_d   = CntLoad;
               end
            end else begin
               state_d = StIdle;
            end
         end
         StWait: begin
            if (cnt_q == '0) begin
               state_d = StData;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StErr1: state_d = StErr2;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      hready = 1'b1;
      hresp  = 1'b0;
      unique case (state_q)
         StIdle: begin
            hready = 1'b1;
            hresp  = 1'b0;
         end
         StWait: begin
            hready = 1'b0;
            hresp  = 1'b0;
         end
         StData: begin
            hready = 1'b1;
            hresp  = 1'b0;
         end
         StErr1: begin
            hready = 1'b0;
            hresp  = 1'b1;
         end
         StErr2: begin
            hready = 1'b1;
            hresp  = 1'b1;
         end
         default: begin
            hready = 1'b1;
            hresp  = 1'b0;
         end
      endcase
   end

   // Write data is taken on the edge that ends the data phase, so hwdata during WAIT is ignored.
   assign mem_we = (state_q == StData) & write_q & legal_q;

   always_ff @(posedge hclk) begin
      if (mem_we) begin
         for (int unsigned b = 0; b < Bytes; b++) begin
            if (hwstrb[b]) begin
               mem[idx][8*b +: 8] <= hwdata[8*b +: 8];
            end
         end
      end
   end

   assign hrdata = (state_q == StData) ? mem[idx] : '0;

   logic unused_sigs;
   assign unused_sigs = ^{hburst, htrans[0], size_q};

endmodule

// File: tb/tb_renode_ahb_memory_subordinate.sv
// Directed bench: four subordinates (wait states 0/2/3/1, the last with a non-zero base)
// share one bus; each transfer selects exactly one of them.
module tb_renode_ahb_memory_subordinate;

   logic        hclk;
   logic        hresetn;
   logic [3:0]  hsel_v;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [2:0]  hburst;
   logic [3:0]  hwstrb;
   logic [31:0] hwdata;
   logic        hready_v [4];
   logic        hresp_v  [4];
   logic [31:0] hrdata_v [4];

   int n_vec;
   int n_miss;

   renode_ahb_memory_subordinate #(.WaitStates(0)) u_ws0 (
      .hclk(hclk), .hresetn(hresetn), .hsel(hsel_v[0]), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwstrb(hwstrb), .hwdata(hwdata),
      .hready(hready_v[0]), .hresp(hresp_v[0]), .hrdata(hrdata_v[0])
   );
   renode_ahb_memory_subordinate #(.WaitStates(2)) u_ws2 (
      .hclk(hclk), .hresetn(hresetn), .hsel(hsel_v[1]), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwstrb(hwstrb), .hwdata(hwdata),
      .hready(hready_v[1]), .hresp(hresp_v[1]), .hrdata(hrdata_v[1])
   );
   renode_ahb_memory_subordinate #(.WaitStates(3)) u_ws3 (
      .hclk(hclk), .hresetn(hresetn), .hsel(hsel_v[2]), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwstrb(hwstrb), .hwdata(hwdata),
      .hready(hready_v[2]), .hresp(hresp_v[2]), .hrdata(hrdata_v[2])
   );
   renode_ahb_memory_subordinate #(.Depth(16), .BaseAddress(32'h1000), .WaitStates(1)) u_base (
      .hclk(hclk), .hresetn(hresetn), .hsel(hsel_v[3]), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwstrb(hwstrb), .hwdata(hwdata),
      .hready(hready_v[3]), .hresp(hresp_v[3]), .hrdata(hrdata_v[3])
   );

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   typedef struct {
      int          inst;
      bit          wr;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [31:0] wdata;
      logic [3:0]  strb;
      int          lows;
      bit          err;
      logic [31:0] rdata;
   } vec_t;

   localparam int NumVec = 20;
   vec_t vecs [NumVec];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One non-pipelined transfer; counts hready-low cycles and samples the final data-phase cycle.
   task automatic do_xfer(input int inst, input bit wr, input logic [31:0] addr,
                          input logic [2:0] size, input logic [31:0] wdata,
                          input logic [3:0] strb, output int lows, output logic low_resp,
                          output logic fresp, output logic [31:0] frdata);
      bit done;
      @(negedge hclk);
      hsel_v       = '0;
      hsel_v[inst] = 1'b1;
      haddr        = addr;
      htrans       = 2'd2;
      hwrite       = wr;
      hsize        = size;
      @(posedge hclk);
      #1;
      hsel_v = '0;
      htrans = 2'd0;
      hwdata = wdata;
      hwstrb = strb;
      lows     = 0;
      low_resp = 1'b0;
      fresp    = 1'b0;
      frdata   = '0;
      done     = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
         @(negedge hclk);
         if (hready_v[inst]) begin
            done   = 1'b1;
            fresp  = hresp_v[inst];
            frdata = hrdata_v[inst];
         end else begin
            lows++;
            low_resp = low_resp | hresp_v[inst];
         end
      end
      @(posedge hclk);
      #1;
      hwdata = '0;
      hwstrb = '0;
   endtask

   initial begin
      int          lows;
      logic        low_resp, fresp;
      logic [31:0] frdata;

      n_vec  = 0;
      n_miss = 0;
      hresetn = 1'b0;
      hsel_v  = '0;
      haddr   = '0;
      htrans  = 2'd0;
      hwrite  = 1'b0;
      hsize   = 3'd0;
      hburst  = 3'd0;
      hwstrb  = '0;
      hwdata  = '0;

      //           inst wr  addr          sz    wdata          strb  lows err rdata
      vecs[0]  = '{0, 1'b1, 32'h0000_0008, 3'd2, 32'hFFFF_FFFF, 4'hF, 0, 1'b0, 32'h0};
      vecs[1]  = '{0, 1'b1, 32'h0000_0008, 3'd2, 32'h0000_00AA, 4'h1, 0, 1'b0, 32'h0};
      vecs[2]  = '{0, 1'b0, 32'h0000_0008, 3'd2, 32'h0,         4'h0, 0, 1'b0, 32'hFFFF_FFAA};
      vecs[3]  = '{0, 1'b1, 32'h0000_0000, 3'd2, 32'h1122_3344, 4'hF, 0, 1'b0, 32'h0};
      vecs[4]  = '{0, 1'b1, 32'h0000_1000, 3'd2, 32'hAAAA_AAAA, 4'hF, 1, 1'b1, 32'h0};
      vecs[5]  = '{0, 1'b1, 32'h0000_0000, 3'd3, 32'hBBBB_BBBB, 4'hF, 1, 1'b1, 32'h0};
      vecs[6]  = '{0, 1'b1, 32'h0000_0001, 3'd1, 32'hCCCC_CCCC, 4'hF, 1, 1'b1, 32'h0};
      vecs[7]  = '{0, 1'b0, 32'h0000_0000, 3'd2, 32'h0,         4'h0, 0, 1'b0, 32'h1122_3344};
      vecs[8]  = '{0, 1'b1, 32'h0000_000C, 3'd2, 32'h0,         4'hF, 0, 1'b0, 32'h0};
      vecs[9]  = '{0, 1'b1, 32'h0000_000E, 3'd1, 32'h5566_0000, 4'hC, 0, 1'b0, 32'h0};
      vecs[10] = '{0, 1'b0, 32'h0000_000C, 3'd2, 32'h0,         4'h0, 0, 1'b0, 32'h5566_0000};
      vecs[11] = '{0, 1'b0, 32'h0000_0003, 3'd0, 32'h0,         4'h0, 0, 1'b0, 32'h1122_3344};
      vecs[12] = '{1, 1'b1, 32'h0000_0004, 3'd2, 32'hCAFE_F00D, 4'hF, 2, 1'b0, 32'h0};
      vecs[13] = '{1, 1'b0, 32'h0000_0004, 3'd2, 32'h0,         4'h0, 2, 1'b0, 32'hCAFE_F00D};
      vecs[14] = '{3, 1'b1, 32'h0000_1004, 3'd2, 32'hA5A5_A5A5, 4'hF, 1, 1'b0, 32'h0};
      vecs[15] = '{3, 1'b0, 32'h0000_1004, 3'd2, 32'h0,         4'h0, 1, 1'b0, 32'hA5A5_A5A5};
      vecs[16] = '{3, 1'b0, 32'h0000_0FFC, 3'd2, 32'h0,         4'h0, 1, 1'b1, 32'h0};
      vecs[17] = '{3, 1'b0, 32'h0000_1040, 3'd2, 32'h0,         4'h0, 1, 1'b1, 32'h0};
      vecs[18] = '{3, 1'b1, 32'h0000_103C, 3'd2, 32'h0F0F_0F0F, 4'hF, 1, 1'b0, 32'h0};
      vecs[19] = '{3, 1'b0, 32'h0000_103C, 3'd2, 32'h0,         4'h0, 1, 1'b0, 32'h0F0F_0F0F};

      #12;
      chk("reset_hready", 32'(hready_v[0]), 32'h1);
      chk("reset_hresp",  32'(hresp_v[0]),  32'h0);
      chk("reset_hrdata", hrdata_v[0],      32'h0);
      @(negedge hclk);
      hresetn = 1'b1;
      repeat (2) @(negedge hclk);
      chk("post_reset_hready", 32'(hready_v[2]), 32'h1);

      for (int i = 0; i < NumVec; i++) begin
         do_xfer(vecs[i].inst, vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].wdata,
                 vecs[i].strb, lows, low_resp, fresp, frdata);
         chk($sformatf("v%0d_lows", i), 32'(lows), 32'(vecs[i].lows));
         chk($sformatf("v%0d_low_resp", i), 32'(low_resp), 32'(vecs[i].err));
         chk($sformatf("v%0d_resp", i), 32'(fresp), 32'(vecs[i].err));
         if (!vecs[i].wr && !vecs[i].err) begin
            chk($sformatf("v%0d_rdata", i), frdata, vecs[i].rdata);
         end
      end

      // Back-to-back write then read of word 0 with no wait states.
      @(negedge hclk);
      hsel_v = 4'b0001;
      haddr  = 32'h0;
      htrans = 2'd2;
      hwrite = 1'b1;
      hsize  = 3'd2;
      @(posedge hclk);
      #1;
      hwdata = 32'h1234_5678;
      hwstrb = 4'hF;
      hwrite = 1'b0;
      @(negedge hclk);
      chk("b2b_wr_hready", 32'(hready_v[0]), 32'h1);
      chk("b2b_wr_hresp",  32'(hresp_v[0]),  32'h0);
      @(posedge hclk);
      #1;
      hsel_v = '0;
      htrans = 2'd0;
      hwdata = '0;
      hwstrb = '0;
      @(negedge hclk);
      chk("b2b_rd_hready", 32'(hready_v[0]), 32'h1);
      chk("b2b_rd_hresp",  32'(hresp_v[0]),  32'h0);
      chk("b2b_rd_hrdata", hrdata_v[0],      32'h1234_5678);
      @(posedge hclk);
      #1;

      // Reset during the second wait cycle of a write drops that write.
      do_xfer(2, 1'b1, 32'h10, 3'd2, 32'h0, 4'hF, lows, low_resp, fresp, frdata);
      chk("preload_lows", 32'(lows), 32'd3);
      @(negedge hclk);
      hsel_v = 4'b0100;
      haddr  = 32'h10;
      htrans = 2'd2;
      hwrite = 1'b1;
      hsize  = 3'd2;
      @(posedge hclk);
      #1;
      hsel_v = '0;
      htrans = 2'd0;
      hwdata = 32'hDEAD_BEEF;
      hwstrb = 4'hF;
      @(negedge hclk);
      chk("rst_wait1_hready", 32'(hready_v[2]), 32'h0);
      @(negedge hclk);
      hresetn = 1'b0;
      #1;
      chk("rst_mid_hready", 32'(hready_v[2]), 32'h1);
      chk("rst_mid_hresp",  32'(hresp_v[2]),  32'h0);
      chk("rst_mid_hrdata", hrdata_v[2],      32'h0);
      @(negedge hclk);
      hresetn = 1'b1;
      @(posedge hclk);
      #1;
      hwdata = '0;
      hwstrb = '0;
      do_xfer(2, 1'b0, 32'h10, 3'd2, 32'h0, 4'h0, lows, low_resp, fresp, frdata);
      chk("rst_rd_lows",  32'(lows),  32'd3);
      chk("rst_rd_resp",  32'(fresp), 32'h0);
      chk("rst_rd_rdata", frdata,     32'h0);

      // Idle, Busy and deselected NonSequential are never accepted.
      for (int p = 0; p < 3; p++) begin
         @(negedge hclk);
         hsel_v = (p == 2) ? 4'b0000 : 4'b0010;
         htrans = (p == 2) ? 2'd2 : 2'(p);
         haddr  = 32'h4;
         hwrite = 1'b0;
         hsize  = 3'd2;
         @(posedge hclk);
         #1;
         @(negedge hclk);
         chk($sformatf("noacc%0d_hready", p), 32'(hready_v[1]), 32'h1);
         chk($sformatf("noacc%0d_hresp", p),  32'(hresp_v[1]),  32'h0);
         chk($sformatf("noacc%0d_hrdata", p), hrdata_v[1],      32'h0);
      end
      hsel_v = '0;
      htrans = 2'd0;
      @(posedge hclk);
      #1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout, expected completion");
      $fatal(1, "bench timeout");
   end

endmodule

// File: doc/renode_ahb_memory_subordinate.md
# renode_ahb_memory_subordinate

Synthesizable AHB-Lite subordinate backed by a word-addressed memory array. It is the responder-side counterpart of the Renode AHB manager: it lets co-simulation benches exercise the manager and the bus protocol against real RTL rather than a behavioural model. The block has a configurable number of wait states and returns the two-cycle ERROR response for illegal transfers.

## Interface
- AddressWidth, 32: width of haddr.
- DataWidth, 32: width of hwdata/hrdata; one of 8, 16, 32, 64.
- Depth, 1024: number of DataWidth-bit words in the array.
- BaseAddress, 0: byte address of word 0.
- WaitStates, 0: hready-low cycles inserted in every OKAY data phase (0–15).
- hclk  in  1  clock; all logic on posedge.
- hresetn  in  1  reset, asynchronous, active-low.
- hsel  in  1  subordinate select.
- haddr  in  AddressWidth  byte address (address phase).
- htrans  in  2  0 Idle, 1 Busy, 2 NonSequential, 3 Sequential.
- hwrite  in  1  1 = write.
- hsize  in  3  log2 of transfer bytes.
- hburst  in  3  ignored; every beat is handled independently.
- hwstrb  in  DataWidth/8  write byte strobes (data phase).
- hwdata  in  DataWidth  write data (data phase).
- hready  out  1  data phase complete; also qualifies the next address phase.
- hresp  out  1  0 OKAY, 1 ERROR.
- hrdata  out  DataWidth  read data.

## Operation
- Transfer accepted on a posedge with hready=1, hsel=1 and htrans[1]=1. Idle or Busy, or hsel=0, is not accepted. It receives the zero-wait OKAY response, and the state is not otherwise changed.
- On accept, latch: addr, write, size, and a legal flag.
- A transfer is illegal if any of these holds:
  - hsize > log2(DataWidth/8);
  - haddr is not aligned to 2^hsize;
  - haddr < BaseAddress;
  - haddr >= BaseAddress + Depth*DataWidth/8.
- Word index = (addr − BaseAddress) >> log2(DataWidth/8).
- States:
  - IDLE: hready=1, hresp=0.
  - WAIT: hready=0, hresp=0, wait counter decrements.
  - DATA: hready=1, hresp=0.
  - ERR1: hready=0, hresp=1.
  - ERR2: hready=1, hresp=1.
- Transitions on accept:
  - legal and WaitStates=0 → DATA;
  - legal and WaitStates>0 → WAIT, counter loaded with WaitStates−1; WAIT→DATA when counter=0;
  - illegal → ERR1, then ERR2 unconditionally.
- From DATA or ERR2: a new accept in the same edge is handled as above; otherwise → IDLE.
- Write commit: at the posedge ending DATA, mem[index] byte lanes with hwstrb=1 take hwdata, and the other lanes are unchanged. Illegal transfers never write.
- Read: during DATA, hrdata = mem[index] as a full word, with no lane shifting. Outside DATA, hrdata = 0.
- The array is not reset; its contents are undefined until written.

## Timing
- Reset (async assert): state IDLE, hready=1, hresp=0, hrdata=0, latched fields cleared, counter=0. An in-flight write is dropped.
- Release is synchronous to the next posedge. Outputs hold their reset values until the first accept.
- OKAY latency, measured from the accept edge: the data phase ends at edge 1+WaitStates. hready is low for exactly WaitStates cycles.
- ERROR: exactly 2 cycles — hready low with hresp high, then hready high with hresp high.
- Pipelined back-to-back transfers: the next address phase is sampled on the edge that ends the current data phase. There are no idle cycles between transfers when WaitStates=0.
- Read after write, back-to-back to the same word: the read data phase returns the newly written data.
- hwdata and hwstrb are sampled only on the edge ending DATA. Values during WAIT are ignored.
- The manager's htrans going to Idle mid data phase does not affect the current response.

## Test plan
- Reset mid WAIT (WaitStates=3; write 0xDEADBEEF to 0x10, assert hresetn=0 during the 2nd wait cycle) → hready=1, hresp=0 immediately. A later read of 0x10 does not return 0xDEADBEEF: pre-load 0x10 with 0 and expect 0.
- WaitStates=0: write 0x12345678 to 0x0 with hwstrb=0xF, then a back-to-back read of 0x0 → no hready-low cycles; hrdata=0x12345678 in the read data phase; hresp=0.
- WaitStates=2: read 0x4 holding 0xCAFEF00D → hready low for exactly 2 cycles; hrdata=0xCAFEF00D on the hready-high cycle.
- Byte strobes: word 0x8 = 0xFFFFFFFF; write 0x000000AA with hwstrb=0x1 → read returns 0xFFFFFFAA.
- Errors, each giving the 2-cycle ERROR sequence and no memory change:
  - write to BaseAddress + Depth*4;
  - hsize=3 on the 32-bit bus;
  - halfword at 0x1.
  - After these, a read of 0x0 returns OKAY.
- Idle and Busy: htrans=0 or 1, and hsel=0 with htrans=2 → hready stays 1, hresp=0, no state change, hrdata=0.
